// File: rtl/sfp_ctrl_if.sv
// Handshake/bus bundle between the softmax sequencer, psum memory, sfp_row and the peer core.
interface sfp_ctrl_if #(parameter int aw = 4);
  logic          start;
  logic [aw-1:0] base_addr;
  logic          busy;
  logic          done;
  logic          mem_rd;
  logic [aw-1:0] mem_rd_addr;
  logic          mem_wr;
  logic [aw-1:0] mem_wr_addr;
  logic          acc;
  logic          div;
  logic          fifo_ext_rd;
  logic          sync_out;
  logic          sync_in;

  modport master (
    output start, base_addr, sync_in,
    input  busy, done, mem_rd, mem_rd_addr, mem_wr, mem_wr_addr,
           acc, div, fifo_ext_rd, sync_out
  );

  modport slave (
    input  start, base_addr, sync_in,
    output busy, done, mem_rd, mem_rd_addr, mem_wr, mem_wr_addr,
           acc, div, fifo_ext_rd, sync_out
  );
endinterface

// File: rtl/sfp_ctrl.sv
// Two-pass softmax sequencer: accumulate abs-sums, sync with peer core, then divide and write back.
module sfp_ctrl #(
  parameter int len    = 8,
  parameter int aw     = 4,
  parameter int rd_lat = 1
) (
  input logic       clk,
  input logic       reset,
  sfp_ctrl_if.slave bus
);
  localparam int CW = $clog2(len + rd_lat + 2);

  typedef enum logic [2:0] {IDLE, ACC_RD, ACC_DRAIN, SYNC, DIV_RD, DIV_DRAIN} state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [aw-1:0]            r_base;
  logic [aw-1:0]            r_rd_addr;
  logic                     r_busy, r_done, r_mem_rd, r_fifo_rd, r_sync_out, r_mem_wr;
  logic [rd_lat-1:0]        r_acc_pipe;
  logic [rd_lat-1:0]        r_div_pipe;
  logic [rd_lat:0][aw-1:0]  r_wa_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_base     <= '0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_fifo_rd  <= 1'b0;
      r_sync_out <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_acc_pipe <= '0;
      r_div_pipe <= '0;
      r_wa_pipe  <= '0;
    end else begin
      r_done <= 1'b0;
      // Read issues travel down the pipes; pass 2 issues are marked by fifo_ext_rd.
      r_acc_pipe[0] <= r_mem_rd & ~r_fifo_rd;
      r_div_pipe[0] <= r_fifo_rd;
      for (int k = 1; k < rd_lat; k++) begin
        r_acc_pipe[k] <= r_acc_pipe[k-1];
        r_div_pipe[k] <= r_div_pipe[k-1];
      end
      r_mem_wr     <= r_div_pipe[rd_lat-1];
      r_wa_pipe[0] <= r_rd_addr;
      for (int k = 1; k <= rd_lat; k++) r_wa_pipe[k] <= r_wa_pipe[k-1];

      case (r_state)
        IDLE: begin
          // r_done high means this is the done cycle, where start must be ignored.
          if (bus.start && !r_done) begin
            r_base    <= bus.base_addr;
            r_rd_addr <= bus.base_addr;
            r_busy    <= 1'b1;
            r_mem_rd  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ACC_RD;
          end
        end
        ACC_RD: begin
          if (r_cnt == CW'(len - 1)) begin
            r_mem_rd <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ACC_DRAIN;
          end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_rd_addr <= r_rd_addr + aw'(1);
          end
        end
        ACC_DRAIN: begin
          // Covers the read latency plus two cycles for the sfp_row FIFO write.
          if (r_cnt == CW'(rd_lat + 1)) begin
            r_sync_out <= 1'b1;
            r_state    <= SYNC;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        SYNC: begin
          if (bus.sync_in) begin
            r_sync_out <= 1'b0;
            r_mem_rd   <= 1'b1;
            r_fifo_rd  <= 1'b1;
            r_rd_addr  <= r_base;
            r_cnt      <= '0;
            r_state    <= DIV_RD;
          end
        end
        DIV_RD: begin
          if (r_cnt == CW'(len - 1)) begin
            r_mem_rd  <= 1'b0;
            r_fifo_rd <= 1'b0;
            r_cnt     <= '0;
            r_state   <= DIV_DRAIN;
          end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_rd_addr <= r_rd_addr + aw'(1);
          end
        end
        DIV_DRAIN: begin
          if (r_cnt == CW'(rd_lat)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.mem_rd      = r_mem_rd;
  assign bus.mem_rd_addr = r_rd_addr;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_wr_addr = r_wa_pipe[rd_lat];
  assign bus.acc         = r_acc_pipe[rd_lat-1];
  assign bus.div         = r_div_pipe[rd_lat-1];
  assign bus.fifo_ext_rd = r_fifo_rd;
  assign bus.sync_out    = r_sync_out;
endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl with len=8, aw=4, rd_lat=1.
module tb_sfp_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  sfp_ctrl_if #(.aw(4)) ifc ();
  sfp_ctrl #(.len(8), .aw(4), .rd_lat(1)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit   rec = 1'b0;
  int   acc_q[$], div_q[$];
  logic [3:0] rd_q[$], wr_q[$];
  int   fifo_n = 0, ovl = 0;

  always @(negedge clk) if (rec) begin
    if (ifc.acc) acc_q.push_back(cyc);
    if (ifc.div) div_q.push_back(cyc);
    if (ifc.mem_rd) rd_q.push_back(ifc.mem_rd_addr);
    if (ifc.mem_wr) wr_q.push_back(ifc.mem_wr_addr);
    if (ifc.fifo_ext_rd) fifo_n++;
    if (ifc.acc && ifc.div) ovl++;
  end

  function automatic logic [9:0] outs();
    return {ifc.busy, ifc.done, ifc.mem_rd, ifc.mem_wr, ifc.acc, ifc.div,
            ifc.fifo_ext_rd, ifc.sync_out, |ifc.mem_rd_addr, |ifc.mem_wr_addr};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (outs() !== 10'd0) begin bad++; $display("FAIL reset_outs got=%b want=0", outs()); end
    reset = 1'b0;
  endtask

  // Runs one full pass and checks timing, addresses and pulse counts.
  task automatic run_pass(input logic [3:0] b, input int sdly, input bit spam, input string nm);
    int t0, s, dc;
    logic [3:0] ea;
    acc_q.delete(); div_q.delete(); rd_q.delete(); wr_q.delete();
    fifo_n = 0; ovl = 0; s = -1; dc = -1;
    ifc.sync_in = (sdly == 0);
    @(negedge clk);
    rec = 1'b1;
    ifc.start = 1'b1; ifc.base_addr = b; t0 = cyc;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (spam) begin ifc.start = 1'b1; ifc.base_addr = 4'h9; end
      else ifc.start = 1'b0;
      if (cyc == t0 + 1) begin
        total++;
        if (ifc.busy !== 1'b1) begin bad++; $display("FAIL %s busy_rise got=%b want=1", nm, ifc.busy); end
      end
      if (sdly > 0) begin
        if (s < 0 && ifc.sync_out) s = cyc;
        if (s >= 0 && cyc <= s + sdly) begin
          total++;
          if (!(ifc.sync_out === 1'b1 && ifc.mem_rd === 1'b0 && ifc.div === 1'b0)) begin
            bad++; $display("FAIL %s sync_wait cyc=%0d sync_out=%b mem_rd=%b div=%b want 1,0,0",
                            nm, cyc - s, ifc.sync_out, ifc.mem_rd, ifc.div);
          end
        end
        if (s >= 0 && cyc == s + sdly) ifc.sync_in = 1'b1;
      end
      if (ifc.done) begin dc = cyc; break; end
    end
    @(negedge clk);
    ifc.start = 1'b0;
    total++;
    if ({ifc.done, ifc.busy, ifc.mem_rd} !== 3'b000) begin
      bad++; $display("FAIL %s after_done done/busy/mem_rd got=%b want=000", nm, {ifc.done, ifc.busy, ifc.mem_rd});
    end
    rec = 1'b0;
    ifc.sync_in = 1'b1;
    total++;
    if (dc != t0 + 23 + sdly) begin bad++; $display("FAIL %s done_time got=%0d want=%0d", nm, dc - t0, 23 + sdly); end
    total++;
    if (acc_q.size() != 8 || div_q.size() != 8 || wr_q.size() != 8 || fifo_n != 8 || rd_q.size() != 16) begin
      bad++; $display("FAIL %s counts acc=%0d div=%0d wr=%0d fifo=%0d rd=%0d want 8,8,8,8,16",
                      nm, acc_q.size(), div_q.size(), wr_q.size(), fifo_n, rd_q.size());
    end
    total++;
    if (ovl != 0) begin bad++; $display("FAIL %s acc_div_overlap got=%0d want=0", nm, ovl); end
    for (int i = 0; i < 8; i++) begin
      ea = b + 4'(i);
      if (i < acc_q.size()) begin
        total++;
        if (acc_q[i] != t0 + 2 + i) begin bad++; $display("FAIL %s acc_time[%0d] got=%0d want=%0d", nm, i, acc_q[i] - t0, 2 + i); end
      end
      if (i < div_q.size()) begin
        total++;
        if (div_q[i] != t0 + 14 + sdly + i) begin
          bad++; $display("FAIL %s div_time[%0d] got=%0d want=%0d", nm, i, div_q[i] - t0, 14 + sdly + i);
        end
      end
      if (i < wr_q.size()) begin
        total++;
        if (wr_q[i] !== ea) begin bad++; $display("FAIL %s wr_addr[%0d] got=%0d want=%0d", nm, i, wr_q[i], ea); end
      end
      if (i + 8 < rd_q.size()) begin
        total++;
        if (rd_q[i] !== ea || rd_q[i+8] !== ea) begin
          bad++; $display("FAIL %s rd_addr[%0d] got=%0d/%0d want=%0d", nm, i, rd_q[i], rd_q[i+8], ea);
        end
      end
    end
  endtask

  task automatic test_basic();      run_pass(4'd0, 0, 1'b0, "basic");  endtask
  task automatic test_sync_wait();  run_pass(4'd0, 10, 1'b0, "sync_wait"); endtask
  task automatic test_wrap();       run_pass(4'd14, 0, 1'b0, "wrap");  endtask
  task automatic test_start_spam(); run_pass(4'd0, 0, 1'b1, "spam");   endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    ifc.sync_in = 1'b1;
    @(negedge clk);
    ifc.start = 1'b1; ifc.base_addr = 4'd2;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      if (ifc.fifo_ext_rd && ifc.mem_rd_addr == 4'd5) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL reset_mid row3_reached got=0 want=1"); end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (outs() !== 10'd0) begin bad++; $display("FAIL reset_mid outs got=%b want=0", outs()); end
    reset = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ifc.done || ifc.busy || ifc.mem_rd || ifc.mem_wr) hit = 1'b1;
    end
    total++;
    if (hit) begin bad++; $display("FAIL reset_mid idle_after got=activity want=none"); end
  endtask

  initial begin
    ifc.start = 1'b0; ifc.base_addr = '0; ifc.sync_in = 1'b1;
    test_reset();
    test_basic();
    test_sync_wait();
    test_wrap();
    test_start_spam();
    test_reset_mid();
    test_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
